// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx -- 8N1 serial UART receiver (8 data bits LSB first, 1 start, 1 stop,
// no parity).
//
// The asynchronous serial line passes through a two-flop synchroniser before
// any decision is made. The start bit is confirmed at its mid-point. Each data
// bit is then sampled one bit period later, which is its centre. The stop bit
// is checked the same way.
//
// Parameters:
//   CLKS_PER_BIT   clock cycles per bit (f_clk / baud), legal range 4..65535
//
// Ports:
//   clk             in   system clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   i_rx_serial     in   asynchronous serial line, idles high
//   o_rx_dv         out  one-cycle pulse: o_rx_byte holds a new good byte
//   o_rx_byte       out  last good byte, held between pulses
//   o_rx_active     out  high while a frame is being received
//   o_rx_frame_err  out  one-cycle pulse: stop bit sampled low
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx_serial,
    output logic       o_rx_dv,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_active,
    output logic       o_rx_frame_err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START_BIT = 3'd1;
    localparam logic [2:0] S_DATA_BITS = 3'd2;
    localparam logic [2:0] S_STOP_BIT  = 3'd3;
    localparam logic [2:0] S_CLEANUP   = 3'd4;

    // Half a bit period, used to reach the middle of the start bit.
    localparam logic [15:0] H_CNT    = 16'((CLKS_PER_BIT - 1) / 2);
    // Last count of a full bit period.
    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    logic        r_rx_sync1;
    logic        r_rx_sync2;
    logic        w_rx_s;
    logic [2:0]  r_state;
    logic [15:0] r_clk_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_rx_dv;
    logic [7:0]  r_rx_byte;
    logic        r_rx_active;
    logic        r_rx_frame_err;

    assign w_rx_s = r_rx_sync2;

    // Two-flop synchroniser. It resets to the idle (high) line level, so a
    // reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_sync1 <= 1'b1;
            r_rx_sync2 <= 1'b1;
        end else begin
            r_rx_sync1 <= i_rx_serial;
            r_rx_sync2 <= r_rx_sync1;
        end
    end

    // Receive state machine, bit timing and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_clk_cnt      <= 16'd0;
            r_bit_idx      <= 3'd0;
            r_shift        <= 8'h00;
            r_rx_dv        <= 1'b0;
            r_rx_byte      <= 8'h00;
            r_rx_active    <= 1'b0;
            r_rx_frame_err <= 1'b0;
        end else begin
            // The two status outputs are single-cycle pulses. Only the
            // stop-bit decision below raises them.
            r_rx_dv        <= 1'b0;
            r_rx_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_clk_cnt <= 16'd0;
                    r_bit_idx <= 3'd0;
                    if (!w_rx_s) begin
                        r_state     <= S_START_BIT;
                        r_rx_active <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_START_BIT: begin
                    if (r_clk_cnt < H_CNT) begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end else if (!w_rx_s) begin
                        r_clk_cnt <= 16'd0;
                        r_state   <= S_DATA_BITS;
                    end else begin
                        // The line went high again before mid-bit, so this
                        // was a glitch. Drop it silently.
                        r_clk_cnt   <= 16'd0;
                        r_rx_active <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                S_DATA_BITS: begin
                    if (r_clk_cnt < LAST_CNT) begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end else begin
                        r_clk_cnt          <= 16'd0;
                        r_shift[r_bit_idx] <= w_rx_s;
                        if (r_bit_idx < 3'd7) begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end else begin
                            r_bit_idx <= 3'd0;
                            r_state   <= S_STOP_BIT;
                        end
                    end
                end
                S_STOP_BIT: begin
                    if (r_clk_cnt < LAST_CNT) begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end else begin
                        if (w_rx_s) begin
                            r_rx_byte <= r_shift;
                            r_rx_dv   <= 1'b1;
                        end else begin
                            r_rx_frame_err <= 1'b1;
                        end
                        r_rx_active <= 1'b0;
                        r_clk_cnt   <= 16'd0;
                        r_state     <= S_CLEANUP;
                    end
                end
                S_CLEANUP: begin
                    // Wait for the line to return high. A held-low line
                    // (break or bad stop bit) cannot start a new frame.
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_CLEANUP;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_clk_cnt   <= 16'd0;
                    r_bit_idx   <= 3'd0;
                    r_rx_active <= 1'b0;
                end
            endcase
        end
    end

    assign o_rx_dv        = r_rx_dv;
    assign o_rx_byte      = r_rx_byte;
    assign o_rx_active    = r_rx_active;
    assign o_rx_frame_err = r_rx_frame_err;

endmodule
